irq_entry_sequencer: RTL and testbench
======================================

# irq_entry_sequencer

Interrupt acceptance and entry controller for the CPU core. It samples peripheral interrupt requests at instruction boundaries and selects the highest-priority one. It then sequences the return-address push through the stack pointer and status register datapath and redirects the PC to the selected vector. It drives the `irq_det`/`irq_ret` strobes and the SP timing enable consumed by the status register / stack pointer block.

## Interface

Parameters:
- `N_IRQ`, 8: number of interrupt sources; index 0 has the highest priority.
- `PC_W`, 16: program counter width in words; must be ≤ 16.
- `VEC_BASE`, 16'h0000: word address of vector 0 (the reset vector).
- `VEC_STRIDE`, 2: words per vector slot.

Ports:
- `clock`, in, 1: master clock; one clock domain, all state on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `irq_req`, in, N_IRQ: level interrupt requests, already enable-masked by the peripherals.
- `sr_if`, in, 1: global interrupt enable (SREG I).
- `inst_done`, in, 1: one-cycle pulse in the last cycle of each instruction.
- `op_reti`, in, 1: decoded RETI is the current instruction.
- `op_sei`, in, 1: decoded SEI (BSET 7) is the current instruction.
- `pc_ret`, in, PC_W: return address, valid while `inst_done`=1.
- `irq_det`, out, 1: acceptance strobe; clears I and enables the I update.
- `irq_ret`, out, 1: RETI completion strobe; sets I.
- `irq_ack`, out, N_IRQ: one-hot acknowledge to the serviced source.
- `stall`, out, 1: freezes fetch/decode while the sequence runs.
- `sp_dec`, out, 1: SP decrement timing enable, paired with the stack write.
- `st_we`, out, 1: data-memory write at the current SP.
- `st_wdata`, out, 8: byte to push.
- `vec_we`, out, 1: load the PC from `vec_pc`.
- `vec_pc`, out, PC_W: vector address.

## Operation

The state machine has four states: IDLE, PUSH_L, PUSH_H, JUMP.

Acceptance condition, IDLE only: `inst_done & sr_if & ~shadow & |irq_req`. When it holds:
- Latch `idx` = lowest set bit of `irq_req`.
- Latch `pc_q` = `pc_ret`.
- Go to PUSH_L.

State outputs:
- PUSH_L:
  - `stall`=1, `irq_det`=1, `irq_ack[idx]`=1.
  - `st_we`=1, `sp_dec`=1, `st_wdata` = `pc_q[7:0]`.
  - Next state: PUSH_H.
- PUSH_H:
  - `stall`=1, `st_we`=1, `sp_dec`=1.
  - `st_wdata` = `pc_q[15:8]`, with bits at or above PC_W zero-filled.
  - Next state: JUMP.
- JUMP:
  - `stall`=1, `vec_we`=1.
  - `vec_pc` = VEC_BASE + (idx+1)·VEC_STRIDE, truncated to PC_W.
  - Next state: IDLE.

`vec_pc` is driven from the latched `idx` in every state. All other outputs are 0 unless listed above.

Shadow flag:
- Set at any `inst_done` with `op_reti` or `op_sei`.
- Cleared at the next `inst_done` that has neither.
- While set, acceptance is blocked, so exactly one instruction executes after RETI/SEI before the next interrupt.

`irq_ret` = `inst_done & op_reti`. It is combinational and not gated by state.

## Timing

- Reset value of every output is 0, including `irq_ack`, `st_wdata` and `vec_pc`. State resets to IDLE, `shadow`=0, `idx`=0, `pc_q`=0.
- Latency: acceptance at cycle t gives:
  - PUSH_L in t+1: `irq_det`, first push.
  - PUSH_H in t+2.
  - JUMP in t+3: `vec_we`.
  - IDLE in t+4; the vector instruction is fetched in t+4.
- `irq_det` and `irq_ack` are exactly one cycle wide per accepted interrupt.
- Requests change after the acceptance edge: ignored; a request deasserted after acceptance is still serviced with the latched `idx`.
- Multiple requests active at acceptance: only the lowest index is taken. Others stay pending and can be taken no earlier than the boundary after the first vector instruction, subject to I.
- `inst_done` outside IDLE: ignored for both acceptance and shadow. `irq_ret` still follows the combinational rule.
- `sr_if`=0 at the boundary: no acceptance, regardless of requests.
- `reset_n` low mid-sequence: immediate return to IDLE with all outputs 0; the partial push is abandoned.

## Structure

- Shared package `irq_pkg`:
  - State encoding constants `S_IDLE`=2'd0, `S_PUSH_L`=2'd1, `S_PUSH_H`=2'd2, `S_JUMP`=2'd3.
  - Default values of `N_IRQ`, `VEC_STRIDE` and `VEC_BASE`.
- Sub-module `irq_prio_enc`: combinational, N_IRQ-wide, fixed-priority encoder with outputs `any` and `idx` [$clog2(N_IRQ)-1:0].
- Top level contains only the FSM, the shadow flag and the `idx`/`pc_q` registers.

## Test plan

- Single request: `irq_req`=8'h04, `sr_if`=1, `inst_done` with `pc_ret`=16'h1234.
  - `irq_det` and `irq_ack`=8'h04 at t+1; `st_wdata` 8'h34 at t+1, 8'h12 at t+2.
  - `sp_dec` high for 2 cycles; `vec_pc`=16'h0006 with `vec_we` at t+3.
- Priority: `irq_req`=8'h90. Index 4 is serviced with `vec_pc`=16'h000A; bit 7 stays pending and is accepted at a later boundary with `vec_pc`=16'h0010.
- I clear: `sr_if`=0, `irq_req`=8'hFF, 10 `inst_done` pulses. `irq_det`, `st_we` and `vec_we` are never asserted.
- RETI shadow: `inst_done`+`op_reti` with a request pending and `sr_if` rising next cycle.
  - `irq_ret`=1 in that cycle.
  - No acceptance at the first following boundary; acceptance at the second.
- Request drop: `irq_req`=8'h01 deasserts at t+1. The sequence completes with `vec_pc`=16'h0002.
- Reset mid-sequence: `reset_n` low during PUSH_H. All outputs are 0 immediately; after release the state is IDLE and there is no `vec_we`.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt entry sequencer: FSM state
// encoding, parameter defaults and the vector address helper.
package irq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PUSH_L = 2'd1,
        S_PUSH_H = 2'd2,
        S_JUMP   = 2'd3
    } state_t;

    localparam int          N_IRQ_DEF      = 8;
    localparam int          PC_W_DEF       = 16;
    localparam int          VEC_STRIDE_DEF = 2;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0000;

    // Vector slot 0 is the reset vector, so source idx lands in slot idx+1.
    function automatic logic [31:0] vec_addr(input logic [15:0] base,
                                             input logic [31:0] idx,
                                             input logic [31:0] stride);
        return {16'h0000, base} + ((idx + 32'd1) * stride);
    endfunction

endpackage

// File: rtl/irq_entry_sequencer_if.sv
// Bundle of the CPU-facing signals of the interrupt entry sequencer.
// master = core/peripheral side, slave = the sequencer itself.
interface irq_entry_sequencer_if
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int PC_W  = PC_W_DEF
);

    logic [N_IRQ-1:0] irq_req;
    logic             sr_if;
    logic             inst_done;
    logic             op_reti;
    logic             op_sei;
    logic [PC_W-1:0]  pc_ret;

    logic             irq_det;
    logic             irq_ret;
    logic [N_IRQ-1:0] irq_ack;
    logic             stall;
    logic             sp_dec;
    logic             st_we;
    logic [7:0]       st_wdata;
    logic             vec_we;
    logic [PC_W-1:0]  vec_pc;

    modport master (
        output irq_req, sr_if, inst_done, op_reti, op_sei, pc_ret,
        input  irq_det, irq_ret, irq_ack, stall, sp_dec, st_we, st_wdata,
               vec_we, vec_pc
    );

    modport slave (
        input  irq_req, sr_if, inst_done, op_reti, op_sei, pc_ret,
        output irq_det, irq_ret, irq_ack, stall, sp_dec, st_we, st_wdata,
               vec_we, vec_pc
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest set bit (index 0 wins).
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    localparam int IW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic             any,
    output logic [IW-1:0]    idx
);

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                idx = IW'(i);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/irq_entry_sequencer.sv
// Interrupt acceptance and entry controller: picks the highest-priority
// request at an instruction boundary, pushes the return address and jumps.
module irq_entry_sequencer
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = N_IRQ_DEF,
    parameter int          PC_W       = PC_W_DEF,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    irq_entry_sequencer_if.slave  bus
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_t           state_q, state_d;
    logic             shadow_q, shadow_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [PC_W-1:0]  pc_q, pc_d;

    logic             any_s;
    logic [IW-1:0]    enc_idx_s;
    logic             accept_s;
    logic [15:0]      pc_ext_s;
    logic [31:0]      vec_full_s;

    logic             irq_det_q, irq_det_d;
    logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
    logic             stall_q, stall_d;
    logic             sp_dec_q, sp_dec_d;
    logic             st_we_q, st_we_d;
    logic [7:0]       st_wdata_q, st_wdata_d;
    logic             vec_we_q, vec_we_d;
    logic [PC_W-1:0]  vec_pc_q, vec_pc_d;

    irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
        .req (bus.irq_req),
        .any (any_s),
        .idx (enc_idx_s)
    );

    assign accept_s = (state_q == S_IDLE) & bus.inst_done & bus.sr_if
                    & ~shadow_q & any_s;

    // Next-state logic; boundaries outside IDLE touch neither acceptance nor shadow.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        pc_d     = pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.inst_done) begin
                    shadow_d = bus.op_reti | bus.op_sei;
                end else begin
                    shadow_d = shadow_q;
                end
                if (accept_s) begin
                    state_d = S_PUSH_L;
                    idx_d   = enc_idx_s;
                    pc_d    = bus.pc_ret;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUSH_L: state_d = S_PUSH_H;
            S_PUSH_H: state_d = S_JUMP;
            S_JUMP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Zero-extended return address so the high push byte is well defined for PC_W < 16.
    always_comb begin
        pc_ext_s           = 16'h0000;
        pc_ext_s[PC_W-1:0] = pc_d;
    end

    assign vec_full_s = vec_addr(VEC_BASE, 32'(idx_d), 32'(VEC_STRIDE));

    // Outputs decoded from the next state so they register glitch-free and reset to zero.
    always_comb begin
        irq_det_d  = 1'b0;
        irq_ack_d  = '0;
        stall_d    = 1'b0;
        sp_dec_d   = 1'b0;
        st_we_d    = 1'b0;
        st_wdata_d = 8'h00;
        vec_we_d   = 1'b0;
        vec_pc_d   = vec_full_s[PC_W-1:0];
        case (state_d)
            S_PUSH_L: begin
                stall_d           = 1'b1;
                irq_det_d         = 1'b1;
                irq_ack_d[idx_d]  = 1'b1;
                st_we_d           = 1'b1;
                sp_dec_d          = 1'b1;
                st_wdata_d        = pc_ext_s[7:0];
            end
            S_PUSH_H: begin
                stall_d    = 1'b1;
                st_we_d    = 1'b1;
                sp_dec_d   = 1'b1;
                st_wdata_d = pc_ext_s[15:8];
            end
            S_JUMP: begin
                stall_d  = 1'b1;
                vec_we_d = 1'b1;
            end
            S_IDLE:  stall_d = 1'b0;
            default: stall_d = 1'b0;
        endcase
    end

    // State, shadow flag and latched request/return address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shadow_q <= 1'b0;
            idx_q    <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            pc_q     <= pc_d;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_det_q  <= 1'b0;
            irq_ack_q  <= '0;
            stall_q    <= 1'b0;
            sp_dec_q   <= 1'b0;
            st_we_q    <= 1'b0;
            st_wdata_q <= 8'h00;
            vec_we_q   <= 1'b0;
            vec_pc_q   <= '0;
        end else begin
            irq_det_q  <= irq_det_d;
            irq_ack_q  <= irq_ack_d;
            stall_q    <= stall_d;
            sp_dec_q   <= sp_dec_d;
            st_we_q    <= st_we_d;
            st_wdata_q <= st_wdata_d;
            vec_we_q   <= vec_we_d;
            vec_pc_q   <= vec_pc_d;
        end
    end

    assign bus.irq_det  = irq_det_q;
    assign bus.irq_ack  = irq_ack_q;
    assign bus.stall    = stall_q;
    assign bus.sp_dec   = sp_dec_q;
    assign bus.st_we    = st_we_q;
    assign bus.st_wdata = st_wdata_q;
    assign bus.vec_we   = vec_we_q;
    assign bus.vec_pc   = vec_pc_q;
    // RETI completion is a plain decode of the current boundary, independent of state.
    assign bus.irq_ret  = bus.inst_done & bus.op_reti;

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Directed bench for irq_entry_sequencer: a transaction-level model predicts
// every output each cycle, and literal expectations pin the model.
module tb_irq_entry_sequencer;

    logic clock;
    logic reset_n;

    irq_entry_sequencer_if #(.N_IRQ(8), .PC_W(16)) bus ();

    irq_entry_sequencer #(
        .N_IRQ      (8),
        .PC_W       (16),
        .VEC_BASE   (16'h0000),
        .VEC_STRIDE (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted interrupt queues the three cycles of outputs it must produce.
    typedef struct packed {
        logic       det;
        logic [7:0] ack;
        logic       stall;
        logic       sp_dec;
        logic       st_we;
        logic [7:0] wdata;
        logic       vec_we;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        cur_e;
    rec_t        r;
    logic        m_shadow;
    int          m_idx;
    logic        vec_ok;
    logic        m_idle;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_shadow = 1'b0;
            m_idx    = 0;
            vec_ok   = 1'b0;
        end else begin
            vec_ok = 1'b1;
            m_idle = (exp_q.size() == 0);
            if (!m_idle) void'(exp_q.pop_front());
            if (m_idle && bus.inst_done) begin
                if (bus.sr_if && !m_shadow && bus.irq_req != 8'h00) begin
                    for (int i = 7; i >= 0; i--) if (bus.irq_req[i]) m_idx = i;
                    r = '0; r.det = 1'b1; r.ack = 8'h01 << m_idx; r.stall = 1'b1;
                    r.sp_dec = 1'b1; r.st_we = 1'b1; r.wdata = bus.pc_ret[7:0];
                    exp_q.push_back(r);
                    r = '0; r.stall = 1'b1; r.sp_dec = 1'b1; r.st_we = 1'b1;
                    r.wdata = bus.pc_ret[15:8];
                    exp_q.push_back(r);
                    r = '0; r.stall = 1'b1; r.vec_we = 1'b1;
                    exp_q.push_back(r);
                end
                m_shadow = bus.op_reti | bus.op_sei;
            end
        end
    end

    always @(negedge clock) begin
        cur_e = '0;
        if (exp_q.size() > 0) cur_e = exp_q[0];
        chk("irq_det",  32'(bus.irq_det),  32'(cur_e.det));
        chk("irq_ack",  32'(bus.irq_ack),  32'(cur_e.ack));
        chk("stall",    32'(bus.stall),    32'(cur_e.stall));
        chk("sp_dec",   32'(bus.sp_dec),   32'(cur_e.sp_dec));
        chk("st_we",    32'(bus.st_we),    32'(cur_e.st_we));
        chk("st_wdata", 32'(bus.st_wdata), 32'(cur_e.wdata));
        chk("vec_we",   32'(bus.vec_we),   32'(cur_e.vec_we));
        chk("vec_pc",   32'(bus.vec_pc),   vec_ok ? ((m_idx + 1) * 2) & 32'hFFFF : 32'd0);
        chk("irq_ret",  32'(bus.irq_ret),  32'(bus.inst_done & bus.op_reti));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int seen;

    initial begin
        reset_n       = 1'b0;
        bus.irq_req   = 8'h00;
        bus.sr_if     = 1'b0;
        bus.inst_done = 1'b0;
        bus.op_reti   = 1'b0;
        bus.op_sei    = 1'b0;
        bus.pc_ret    = 16'h0000;
        step(); step();
        chk("rst_vec_pc", 32'(bus.vec_pc), 32'h0);
        chk("rst_stall",  32'(bus.stall),  32'h0);
        chk("rst_ack",    32'(bus.irq_ack), 32'h0);
        reset_n = 1'b1;
        step(); step();

        // Single request
        bus.irq_req = 8'h04; bus.sr_if = 1'b1; bus.inst_done = 1'b1; bus.pc_ret = 16'h1234;
        step(); bus.inst_done = 1'b0;
        chk("single_det",   32'(bus.irq_det),  32'h1);
        chk("single_ack",   32'(bus.irq_ack),  32'h04);
        chk("single_wlo",   32'(bus.st_wdata), 32'h34);
        chk("single_spd1",  32'(bus.sp_dec),   32'h1);
        step();
        chk("single_whi",   32'(bus.st_wdata), 32'h12);
        chk("single_spd2",  32'(bus.sp_dec),   32'h1);
        chk("single_det1w", 32'(bus.irq_det),  32'h0);
        step();
        chk("single_vwe",   32'(bus.vec_we),   32'h1);
        chk("single_vpc",   32'(bus.vec_pc),   32'h0006);
        chk("single_spd3",  32'(bus.sp_dec),   32'h0);
        bus.irq_req = 8'h00;
        step();
        chk("single_end",   32'(bus.stall),    32'h0);
        step();

        // Priority: bit 4 first, bit 7 later; a boundary mid-sequence is ignored
        bus.irq_req = 8'h90; bus.inst_done = 1'b1; bus.pc_ret = 16'h0100;
        step();
        chk("prio_ack4", 32'(bus.irq_ack), 32'h10);
        step(); bus.inst_done = 1'b0;
        step();
        chk("prio_vpc4", 32'(bus.vec_pc), 32'h000A);
        step(); step();
        bus.irq_req = 8'h80; bus.inst_done = 1'b1; bus.pc_ret = 16'h000A;
        step(); bus.inst_done = 1'b0;
        chk("prio_ack7", 32'(bus.irq_ack), 32'h80);
        step(); step();
        chk("prio_vpc7", 32'(bus.vec_pc), 32'h0010);
        bus.irq_req = 8'h00;
        step(); step();

        // Global enable clear
        bus.sr_if = 1'b0; bus.irq_req = 8'hFF; seen = 0;
        for (int k = 0; k < 10; k++) begin
            bus.inst_done = 1'b1; step();
            bus.inst_done = 1'b0; step();
            if (bus.irq_det | bus.st_we | bus.vec_we) seen++;
        end
        chk("iclear_quiet", 32'(seen), 32'h0);
        bus.irq_req = 8'h00;
        step();

        // RETI shadow
        bus.irq_req = 8'h01; bus.sr_if = 1'b0; bus.inst_done = 1'b1; bus.op_reti = 1'b1;
        #1;
        chk("reti_ret", 32'(bus.irq_ret), 32'h1);
        step(); bus.op_reti = 1'b0; bus.sr_if = 1'b1;
        step();
        chk("reti_shadow", 32'(bus.irq_det), 32'h0);
        step(); bus.inst_done = 1'b0;
        chk("reti_accept", 32'(bus.irq_det), 32'h1);
        chk("reti_ack",    32'(bus.irq_ack), 32'h01);
        bus.irq_req = 8'h00;
        step(); step(); step(); step();

        // Request drop after acceptance
        bus.irq_req = 8'h01; bus.inst_done = 1'b1; bus.pc_ret = 16'h2222;
        step(); bus.irq_req = 8'h00; bus.inst_done = 1'b0;
        step(); step();
        chk("drop_vwe", 32'(bus.vec_we), 32'h1);
        chk("drop_vpc", 32'(bus.vec_pc), 32'h0002);
        step(); step();

        // Reset during PUSH_H
        bus.irq_req = 8'h02; bus.inst_done = 1'b1; bus.pc_ret = 16'h5678;
        step(); bus.inst_done = 1'b0; bus.irq_req = 8'h00;
        step();
        chk("rmid_inpush", 32'(bus.st_wdata), 32'h56);
        reset_n = 1'b0;
        #1;
        chk("rmid_stall", 32'(bus.stall),    32'h0);
        chk("rmid_we",    32'(bus.st_we),    32'h0);
        chk("rmid_wdata", 32'(bus.st_wdata), 32'h0);
        chk("rmid_vpc",   32'(bus.vec_pc),   32'h0);
        step(); step();
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.vec_we | bus.stall) seen++;
        end
        chk("rmid_novwe", 32'(seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
